// File: rtl/sensor_read_sched_if.sv
// Bundles the CGRA-side request/result signals and the external sensor bus of sensor_read_sched.
// master = the scheduler itself; slave = the CGRA context unit / sensor bus side.
interface sensor_read_sched_if #(
    parameter int SENSOR_ID_WIDTH   = 8,
    parameter int SENSOR_DATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH   = 2
);
    logic                         EN_I;
    logic [SENSOR_ID_WIDTH-1:0]   SENSOR_ADDR_I;
    logic                         SENSOR_READ_EN_I;
    logic                         CLEAR_I;
    logic                         STALL_O;
    logic                         OVERFLOW_O;
    logic [FIFO_ADDR_WIDTH:0]     PENDING_O;
    logic                         BUS_REQ_O;
    logic [SENSOR_ID_WIDTH-1:0]   BUS_ADDR_O;
    logic                         BUS_ACK_I;
    logic [SENSOR_DATA_WIDTH-1:0] BUS_DATA_I;
    logic                         RESULT_VALID_O;
    logic [SENSOR_DATA_WIDTH-1:0] RESULT_DATA_O;
    logic [SENSOR_ID_WIDTH-1:0]   RESULT_ID_O;
    logic                         RESULT_ERR_O;

    modport master (
        input  EN_I, SENSOR_ADDR_I, SENSOR_READ_EN_I, CLEAR_I, BUS_ACK_I, BUS_DATA_I,
        output STALL_O, OVERFLOW_O, PENDING_O, BUS_REQ_O, BUS_ADDR_O,
               RESULT_VALID_O, RESULT_DATA_O, RESULT_ID_O, RESULT_ERR_O
    );

    modport slave (
        output EN_I, SENSOR_ADDR_I, SENSOR_READ_EN_I, CLEAR_I, BUS_ACK_I, BUS_DATA_I,
        input  STALL_O, OVERFLOW_O, PENDING_O, BUS_REQ_O, BUS_ADDR_O,
               RESULT_VALID_O, RESULT_DATA_O, RESULT_ID_O, RESULT_ERR_O
    );
endinterface

// File: rtl/sensor_read_sched.sv
// Queues CGRA sensor read requests and serialises them onto a req/ack sensor bus with timeout.
// Latency: push to bus request 1 edge, push to result 2 edges minimum; results in push order.
// Backpressure: STALL_O when the request FIFO is full; further requests are dropped and flagged sticky in OVERFLOW_O.
module sensor_read_sched #(
    parameter int SENSOR_ID_WIDTH   = 8,
    parameter int SENSOR_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4,
    parameter int FIFO_ADDR_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                CGRA_CLK_I,
    input  logic                RST_N_I,
    sensor_read_sched_if.master io
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [15:0]              TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t                       state;
    logic [SENSOR_ID_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]     count;
    logic [15:0]                  tmo_cnt;
    logic                         overflow;
    logic                         bus_req;
    logic [SENSOR_ID_WIDTH-1:0]   bus_addr;
    logic [SENSOR_ID_WIDTH-1:0]   held_id;
    logic                         res_vld;
    logic [SENSOR_DATA_WIDTH-1:0] res_dat;
    logic [SENSOR_ID_WIDTH-1:0]   res_id;
    logic                         res_err;

    logic push_req, full, pop, push, ovf_set;

    assign push_req = io.EN_I & io.SENSOR_READ_EN_I;
    assign full     = (count == DEPTH_CNT);
    assign pop      = (state == IDLE) && (count != '0);
    // A full FIFO still accepts a request if the head leaves at the same edge.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_ff @(posedge CGRA_CLK_I) begin
        if (push) fifo_mem[wr_ptr] <= io.SENSOR_ADDR_I;
    end

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)         overflow <= 1'b1;
            else if (io.CLEAR_I) overflow <= 1'b0;
        end
    end

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            bus_req  <= 1'b0;
            bus_addr <= '0;
            held_id  <= '0;
            res_vld  <= 1'b0;
            res_dat  <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        bus_addr <= fifo_mem[rd_ptr];
                        held_id  <= fifo_mem[rd_ptr];
                        bus_req  <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= REQ;
                    end else begin
                        bus_req  <= 1'b0;
                    end
                end
                REQ: begin
                    if (io.BUS_ACK_I) begin
                        res_dat <= io.BUS_DATA_I;
                        res_id  <= held_id;
                        res_err <= 1'b0;
                        res_vld <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Counter would reach TIMEOUT_CYCLES on this edge: abort with an error result.
                        res_dat <= '0;
                        res_id  <= held_id;
                        res_err <= 1'b1;
                        res_vld <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.STALL_O        = full;
    assign io.OVERFLOW_O     = overflow;
    assign io.PENDING_O      = count;
    assign io.BUS_REQ_O      = bus_req;
    assign io.BUS_ADDR_O     = bus_addr;
    assign io.RESULT_VALID_O = res_vld;
    assign io.RESULT_DATA_O  = res_dat;
    assign io.RESULT_ID_O    = res_id;
    assign io.RESULT_ERR_O   = res_err;
endmodule

// File: tb/tb_sensor_read_sched.sv
// Directed bench for sensor_read_sched: capture, FIFO full/overflow, ordering, timeout, enable gating, async reset.
module tb_sensor_read_sched;
    localparam int IDW = 8;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int AW  = 2;
    localparam int TMO = 8;

    typedef struct packed {
        logic           err;
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ack_en = 1'b0;
    logic force_ack = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   base;
    res_t res_q[$];

    sensor_read_sched_if #(.SENSOR_ID_WIDTH(IDW), .SENSOR_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) bus ();

    sensor_read_sched #(
        .SENSOR_ID_WIDTH(IDW), .SENSOR_DATA_WIDTH(DW), .FIFO_DEPTH(DEP),
        .FIFO_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CGRA_CLK_I(clk),
        .RST_N_I   (rst_n),
        .io        (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input int idx, input logic [IDW-1:0] id,
                             input logic err, input logic [DW-1:0] data);
        res_t want;
        want = '{err: err, id: id, data: data};
        if (idx < res_q.size()) check_eq(tag, res_q[idx], want);
        else                    check_eq({tag, "_missing"}, res_q.size(), idx + 1);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_results(input int n, input int budget);
        int left;
        left = budget;
        while (res_q.size() < n && left > 0) begin
            tick();
            left--;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.EN_I = 1'b0;
        bus.SENSOR_READ_EN_I = 1'b0;
        bus.SENSOR_ADDR_I = '0;
        bus.CLEAR_I = 1'b0;
        ack_en = 1'b0;
        force_ack = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    // Sensor bus model: acks one cycle after BUS_REQ_O rises when enabled, or on demand.
    initial begin
        bus.BUS_ACK_I = 1'b0;
        bus.BUS_DATA_I = '0;
        forever begin
            @(negedge clk);
            #1;
            if (force_ack) begin
                bus.BUS_ACK_I = 1'b1;
                bus.BUS_DATA_I = 32'h0BAD0BAD;
            end else if (ack_en && bus.BUS_REQ_O && !bus.BUS_ACK_I) begin
                bus.BUS_ACK_I = 1'b1;
                bus.BUS_DATA_I = (bus.BUS_ADDR_O == 8'h12) ? 32'hDEADBEEF : {24'hC0FFEE, bus.BUS_ADDR_O};
            end else begin
                bus.BUS_ACK_I = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.RESULT_VALID_O)
                res_q.push_back('{err: bus.RESULT_ERR_O, id: bus.RESULT_ID_O, data: bus.RESULT_DATA_O});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.EN_I = 1'b0;
        bus.SENSOR_READ_EN_I = 1'b0;
        bus.SENSOR_ADDR_I = '0;
        bus.CLEAR_I = 1'b0;
        tick(2);
        check_eq("rst_bus_req",  bus.BUS_REQ_O, 0);
        check_eq("rst_valid",    bus.RESULT_VALID_O, 0);
        check_eq("rst_pending",  bus.PENDING_O, 0);
        check_eq("rst_stall",    bus.STALL_O, 0);
        check_eq("rst_overflow", bus.OVERFLOW_O, 0);

        // 1: single read, ack one cycle after request
        do_reset();
        base = res_q.size();
        ack_en = 1'b1;
        bus.EN_I = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I = 8'h12;
        tick();
        bus.SENSOR_READ_EN_I = 1'b0;
        check_eq("t1_pending_after_push", bus.PENDING_O, 1);
        check_eq("t1_req_not_yet",        bus.BUS_REQ_O, 0);
        tick();
        check_eq("t1_req_high",    bus.BUS_REQ_O, 1);
        check_eq("t1_bus_addr",    bus.BUS_ADDR_O, 8'h12);
        check_eq("t1_pending_pop", bus.PENDING_O, 0);
        tick();
        check_eq("t1_valid", bus.RESULT_VALID_O, 1);
        check_eq("t1_data",  bus.RESULT_DATA_O, 32'hDEADBEEF);
        check_eq("t1_id",    bus.RESULT_ID_O, 8'h12);
        check_eq("t1_err",   bus.RESULT_ERR_O, 0);
        check_eq("t1_req_drop", bus.BUS_REQ_O, 0);
        tick();
        check_eq("t1_valid_pulse", bus.RESULT_VALID_O, 0);
        check_eq("t1_data_hold",   bus.RESULT_DATA_O, 32'hDEADBEEF);
        check_eq("t1_count",       res_q.size(), base + 1);

        // 2: overfill with ack withheld, then drain in order
        do_reset();
        base = res_q.size();
        bus.EN_I = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.SENSOR_ADDR_I = 8'(i);
            tick();
        end
        bus.SENSOR_READ_EN_I = 1'b0;
        check_eq("t2_stall",    bus.STALL_O, 1);
        check_eq("t2_overflow", bus.OVERFLOW_O, 1);
        check_eq("t2_pending",  bus.PENDING_O, 4);
        check_eq("t2_req",      bus.BUS_REQ_O, 1);
        check_eq("t2_bus_addr", bus.BUS_ADDR_O, 8'h01);
        ack_en = 1'b1;
        wait_results(base + 5, 40);
        for (int i = 0; i < 5; i++)
            check_res($sformatf("t2_res%0d", i), base + i, 8'(i + 1), 1'b0, {24'hC0FFEE, 8'(i + 1)});
        check_eq("t2_overflow_sticky", bus.OVERFLOW_O, 1);
        tick(3);
        check_eq("t2_no_extra", res_q.size(), base + 5);
        bus.CLEAR_I = 1'b1;
        tick();
        bus.CLEAR_I = 1'b0;
        check_eq("t2_overflow_clr", bus.OVERFLOW_O, 0);

        // 3: timeout after 8 cycles in REQ, late ack discarded
        do_reset();
        base = res_q.size();
        bus.EN_I = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I = 8'h03;
        tick();
        bus.SENSOR_READ_EN_I = 1'b0;
        tick();
        check_eq("t3_req_high", bus.BUS_REQ_O, 1);
        check_eq("t3_bus_addr", bus.BUS_ADDR_O, 8'h03);
        tick(7);
        check_eq("t3_req_still", bus.BUS_REQ_O, 1);
        check_eq("t3_no_early",  bus.RESULT_VALID_O, 0);
        tick();
        check_eq("t3_valid", bus.RESULT_VALID_O, 1);
        check_eq("t3_err",   bus.RESULT_ERR_O, 1);
        check_eq("t3_data",  bus.RESULT_DATA_O, 0);
        check_eq("t3_id",    bus.RESULT_ID_O, 8'h03);
        check_eq("t3_req_drop", bus.BUS_REQ_O, 0);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick(3);
        check_eq("t3_late_ack_ignored", res_q.size(), base + 1);
        check_eq("t3_req_idle", bus.BUS_REQ_O, 0);

        // 4: read strobe without run enable
        do_reset();
        bus.EN_I = 1'b0;
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("t4_pending%0d", i), bus.PENDING_O, 0);
            check_eq($sformatf("t4_req%0d", i), bus.BUS_REQ_O, 0);
        end
        bus.SENSOR_READ_EN_I = 1'b0;

        // 5: push and pop at the same edge while full
        do_reset();
        base = res_q.size();
        bus.EN_I = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.SENSOR_ADDR_I = 8'h21 + 8'(i);
            tick();
        end
        bus.SENSOR_READ_EN_I = 1'b0;
        check_eq("t5_pending_full", bus.PENDING_O, 4);
        check_eq("t5_stall",        bus.STALL_O, 1);
        check_eq("t5_bus_addr",     bus.BUS_ADDR_O, 8'h21);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check_eq("t5_first_valid", bus.RESULT_VALID_O, 1);
        check_eq("t5_first_id",    bus.RESULT_ID_O, 8'h21);
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I = 8'h26;
        tick();
        bus.SENSOR_READ_EN_I = 1'b0;
        check_eq("t5_pending_same", bus.PENDING_O, 4);
        check_eq("t5_no_overflow",  bus.OVERFLOW_O, 0);
        check_eq("t5_next_addr",    bus.BUS_ADDR_O, 8'h22);
        check_eq("t5_next_req",     bus.BUS_REQ_O, 1);
        ack_en = 1'b1;
        wait_results(base + 6, 40);
        check_res("t5_res0", base, 8'h21, 1'b0, 32'h0BAD0BAD);
        for (int i = 1; i < 6; i++)
            check_res($sformatf("t5_res%0d", i), base + i, 8'h21 + 8'(i), 1'b0, {24'hC0FFEE, 8'h21 + 8'(i)});
        check_eq("t5_overflow_end", bus.OVERFLOW_O, 0);

        // 6: asynchronous reset in the middle of a transaction
        do_reset();
        base = res_q.size();
        bus.EN_I = 1'b1;
        bus.SENSOR_READ_EN_I = 1'b1;
        bus.SENSOR_ADDR_I = 8'h44;
        tick();
        bus.SENSOR_ADDR_I = 8'h45;
        tick();
        bus.SENSOR_READ_EN_I = 1'b0;
        check_eq("t6_req_before",     bus.BUS_REQ_O, 1);
        check_eq("t6_pending_before", bus.PENDING_O, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_async",      bus.BUS_REQ_O, 0);
        check_eq("t6_valid_async",    bus.RESULT_VALID_O, 0);
        check_eq("t6_pending_async",  bus.PENDING_O, 0);
        check_eq("t6_addr_async",     bus.BUS_ADDR_O, 0);
        tick();
        rst_n = 1'b1;
        ack_en = 1'b1;
        tick(10);
        check_eq("t6_no_result", res_q.size(), base);
        check_eq("t6_req_idle",  bus.BUS_REQ_O, 0);
        check_eq("t6_pending_idle", bus.PENDING_O, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_read_sched.md
Name: sensor_read_sched

Overview:
- Sits between the sensor context unit and the external sensor bus.
- Captures one sensor read request per enabled CGRA cycle (sensor ID plus read-enable strobe) into a small request FIFO.
- Drains the FIFO one transaction at a time over a req/ack sensor bus, with a per-transaction timeout.
- Returns each result (data, ID, error flag) to the CGRA as a one-cycle valid pulse, in request order.

Parameters:
SENSOR_ID_WIDTH, 8, width of sensor address/ID
SENSOR_DATA_WIDTH, 32, width of sensor data word
FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2
FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH)
TIMEOUT_CYCLES, 255, cycles in REQ without ack before abort; >= 1, fits 16 bits

Ports:
CGRA_CLK_I  in  1  clock; all logic on rising edge
RST_N_I  in  1  reset; asynchronous, active-low
EN_I  in  1  CGRA run enable; gates request capture only
SENSOR_ADDR_I  in  SENSOR_ID_WIDTH  sensor ID of current context
SENSOR_READ_EN_I  in  1  read request strobe of current context
CLEAR_I  in  1  synchronous clear of OVERFLOW_O
STALL_O  out  1  FIFO full
OVERFLOW_O  out  1  sticky; a request was dropped
PENDING_O  out  FIFO_ADDR_WIDTH+1  FIFO occupancy
BUS_REQ_O  out  1  bus transaction request
BUS_ADDR_O  out  SENSOR_ID_WIDTH  bus sensor address
BUS_ACK_I  in  1  bus acknowledge; data valid when high
BUS_DATA_I  in  SENSOR_DATA_WIDTH  bus read data
RESULT_VALID_O  out  1  one-cycle result pulse
RESULT_DATA_O  out  SENSOR_DATA_WIDTH  result data
RESULT_ID_O  out  SENSOR_ID_WIDTH  sensor ID of result
RESULT_ERR_O  out  1  result was a timeout

Behaviour:
- Reset (asynchronous, RST_N_I low):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - All outputs go to 0 immediately, including BUS_REQ_O and OVERFLOW_O.
  - Timeout counter clears.
  - Reset mid-transaction aborts it with no result pulse.
- Push:
  - Occurs at the rising edge where EN_I and SENSOR_READ_EN_I are both 1.
  - If the FIFO is full and no pop happens at the same edge, the request is dropped and OVERFLOW_O is set.
  - Push and pop at the same edge while full: push accepted, count unchanged, no overflow.
- OVERFLOW_O:
  - Stays set until reset, or until CLEAR_I at an edge without a new overflow.
  - If a clear and an overflow occur at the same edge, set wins.
- STALL_O = (count == FIFO_DEPTH). PENDING_O = count. Both are decoded from registers.
- FSM states: IDLE, REQ.
  - IDLE: if count > 0, pop the head, load BUS_ADDR_O and the ID holding register, set BUS_REQ_O=1, clear the timeout counter, go to REQ. Otherwise stay, with BUS_REQ_O=0.
  - REQ, BUS_ACK_I=1 at an edge:
    - Register RESULT_DATA_O=BUS_DATA_I, RESULT_ID_O=held ID, RESULT_ERR_O=0, RESULT_VALID_O=1.
    - BUS_REQ_O=0; go to IDLE.
  - REQ, no ack: increment the timeout counter. When it reaches TIMEOUT_CYCLES:
    - RESULT_VALID_O=1, RESULT_ERR_O=1, RESULT_DATA_O=0, RESULT_ID_O=held ID.
    - BUS_REQ_O=0; go to IDLE.
- Handshake rules:
  - BUS_ADDR_O is stable while BUS_REQ_O=1.
  - BUS_REQ_O is low for at least one cycle between transactions.
  - BUS_ACK_I is ignored in IDLE; a late ack after a timeout is discarded.
- Latency:
  - Request pushed at edge t into an empty FIFO with FSM in IDLE: BUS_REQ_O is high after edge t+1.
  - Ack sampled at edge t+1+k (k >= 1): RESULT_VALID_O is high after that edge for exactly one cycle.
  - Minimum push-to-result latency is 2 edges.
- RESULT_DATA_O, RESULT_ID_O and RESULT_ERR_O hold their last values when RESULT_VALID_O=0.
- EN_I low does not stall the bus FSM: queued requests keep draining.
- FIFO pointers wrap modulo FIFO_DEPTH. Results return strictly in push order.

Test Plan:
1. Reset, then push ID 0x12 with EN_I=1. Bus acks one cycle after BUS_REQ_O rises with data 0xDEADBEEF. Required: BUS_ADDR_O=0x12; RESULT_VALID_O pulses once with DATA=0xDEADBEEF, ID=0x12, ERR=0; PENDING_O returns to 0.
2. Push IDs 1..6 on consecutive edges while bus ack is withheld (DEPTH=4). Required:
   - ID 1 is popped into REQ; IDs 2..5 fill the FIFO; STALL_O=1.
   - ID 6 is dropped and OVERFLOW_O=1.
   - Releasing acks yields results 1..5 in order. OVERFLOW_O stays 1 until CLEAR_I.
3. TIMEOUT_CYCLES=8, push ID 0x3, never ack. Required:
   - RESULT_VALID_O pulses with ERR=1, DATA=0, ID=0x3 after 8 cycles in REQ; BUS_REQ_O drops.
   - An ack arriving after that produces no result.
4. SENSOR_READ_EN_I=1 with EN_I=0 for 5 cycles. Required: no push, PENDING_O=0, BUS_REQ_O stays 0.
5. Full FIFO with a pop and a push at the same edge. Required: count stays 4, OVERFLOW_O stays 0, the pushed ID is returned last.
6. Assert RST_N_I low while in REQ. Required: BUS_REQ_O, RESULT_VALID_O and PENDING_O go to 0 immediately, before the next clock edge, and no result pulse follows after release.
